wave_capture_ctrl: RTL and testbench
====================================

// Module: wave_capture_ctrl
// PURPOSE
//   Capture/display scheduler for the 200x256 waveform plot. Collects triggered
//   8-bit ADC sample records into a ping-pong buffer (2 banks x DEPTH bytes).
//   One bank is being captured while the other is read by the VGA plot path.
//   Banks swap only on a frame boundary, so a displayed frame never tears.
//   vga_data is addressed by pixel column value_x and drives the plot renderer.
// PARAMETERS
//   DEPTH    200   samples per record; equals plot width in pixels
//   DW       8     sample width; plot height is 2**DW rows
//   AW       8     bank address width; 2**AW >= DEPTH
//   TIMEOUT  4096  auto-mode forced trigger after this many valid samples
// PORTS
//   clk           in   1   pixel/system clock
//   rst           in   1   reset; synchronous, active-high
//   adc_data      in   DW  ADC sample
//   adc_valid     in   1   sample strobe; adc_data is taken only when high
//   trig_level    in   DW  trigger threshold (unsigned)
//   auto_mode     in   1   1 = force a trigger after TIMEOUT samples without one
//   run           in   1   level; continuous acquisition
//   single        in   1   1-cycle pulse; arms one acquisition from IDLE
//   frame_sync    in   1   1-cycle pulse at start of vertical blank
//   value_x       in   11  current pixel column
//   vga_data      out  DW  display-bank sample for column value_x
//   state         out  2   0 IDLE, 1 WAIT_TRIG, 2 CAPTURE, 3 DONE
//   swapped       out  1   1-cycle pulse when banks swap
//   auto_trig     out  1   1 = record held for display was force-triggered
// BEHAVIOUR
//   Reset (takes priority over all other inputs):
//     - state=IDLE, disp_bank=0, swapped=0, auto_trig=0, vga_data=0.
//     - wr_addr=0, tcnt=0, have_prev=0. Bank RAM contents are not reset.
//     - A reset in any state aborts the record in progress.
//   Capture writes bank ~disp_bank; display reads bank disp_bank.
//   IDLE: wr_addr=0, tcnt=0, have_prev=0.
//     - If run or single -> WAIT_TRIG. single is ignored outside IDLE.
//   WAIT_TRIG: on each adc_valid: prev<=adc_data, have_prev<=1, tcnt++.
//     - Real trigger: have_prev && prev<trig_level && adc_data>=trig_level.
//       Trigger sample is written at addr 0, wr_addr<=1, pend_auto<=0,
//       state -> CAPTURE.
//     - Forced trigger: no real trigger && auto_mode && tcnt==TIMEOUT-1.
//       Same action as a real trigger, but pend_auto<=1.
//     - Real trigger has priority. Samples without adc_valid are ignored.
//   CAPTURE: on each adc_valid, write adc_data at wr_addr, wr_addr++.
//     - Write at DEPTH-1 -> DONE. No further samples are written.
//     - Deasserting run mid-record does not abort; the record completes.
//   DONE: hold until frame_sync.
//     - On frame_sync: disp_bank toggles, swapped=1 for 1 cycle,
//       auto_trig<=pend_auto.
//     - Next state is WAIT_TRIG if run, else IDLE. tcnt and have_prev clear.
//     - frame_sync in the same cycle the last sample is written does not swap;
//       the swap waits for the next frame_sync.
//     - frame_sync in any state other than DONE has no effect.
//   Read path: vga_data is registered one cycle after value_x.
//     - value_x<DEPTH: vga_data <= bank[disp_bank][value_x[AW-1:0]].
//     - value_x>=DEPTH: vga_data <= 0.
//     - A swap takes effect on reads issued the cycle after the frame_sync.
//   tcnt saturates at TIMEOUT-1 when auto_mode=0. wr_addr never exceeds DEPTH-1.
// TESTING
//   1. run=1, ramp 0..255 with adc_valid every cycle, level=128:
//      - Trigger fires at sample 128 and DONE is reached after 200 writes.
//      - After frame_sync, value_x=0..199 reads back 128..255,0..71.
//   2. Trigger edge: samples 200,200,50,130 at level=128:
//      - The 200->200 pair does not trigger; 50->130 triggers.
//      - bank[0] holds 130 after swap.
//   3. auto_mode=1, constant 10, level=128:
//      - Forced trigger on the 4096th valid sample.
//      - After swap: auto_trig=1 and all 200 reads equal 10.
//   4. single pulse with run=0:
//      - One record, swap on frame_sync, then state=IDLE.
//      - A second single pulse during CAPTURE is ignored.
//   5. Last sample write coincides with frame_sync:
//      - No swap that cycle; swapped pulses on the next frame_sync.
//      - The prior bank stays readable until then.
//   6. rst during CAPTURE: next cycle state=IDLE, disp_bank=0, vga_data=0.
//      Also check that value_x=250 reads 0.

Source files
------------

// File: rtl/wave_capture_ctrl.sv
// wave_capture_ctrl
//   Purpose : capture/display scheduler for the waveform plot. Triggered ADC
//             records are written into one half of a ping-pong sample buffer
//             while the other half feeds the VGA plot renderer. The halves swap
//             only at a frame boundary, so a displayed frame never tears.
//   Latency : vga_data is registered one cycle after value_x. A swap becomes
//             visible on reads issued the cycle after the accepting frame_sync.
//   Backpressure : none. ADC samples are accepted whenever adc_valid is high.
//             Samples that arrive in IDLE or DONE are dropped.
//
// Ports
//   clk         pixel/system clock
//   rst         synchronous active-high reset. It aborts any record in progress.
//   adc_data    ADC sample; adc_valid is its strobe
//   trig_level  rising-edge trigger threshold (unsigned)
//   auto_mode   force a trigger after TIMEOUT samples with no real trigger
//   run         continuous acquisition (level)
//   single      one-shot arm, honoured only in IDLE (pulse)
//   frame_sync  start-of-vertical-blank pulse; lets DONE swap the banks
//   value_x     pixel column being rendered
//   vga_data    display-bank sample for value_x (0 beyond the record width)
//   state       0 IDLE, 1 WAIT_TRIG, 2 CAPTURE, 3 DONE
//   swapped     one-cycle pulse when the banks swap
//   auto_trig   the displayed record was force-triggered
module wave_capture_ctrl #(
  parameter int DEPTH   = 200,
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_valid,
  input  logic [DW-1:0] trig_level,
  input  logic          auto_mode,
  input  logic          run,
  input  logic          single,
  input  logic          frame_sync,
  input  logic [10:0]   value_x,
  output logic [DW-1:0] vga_data,
  output logic [1:0]    state,
  output logic          swapped,
  output logic          auto_trig
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t        st;
  logic          disp_bank;
  logic [AW-1:0] wr_addr;
  logic [TW-1:0] tcnt;
  logic [DW-1:0] prev;
  logic          have_prev;
  logic          pend_auto;

  // Both banks live in one array. The MSB of the index selects the bank.
  logic [DW-1:0] mem [0:(2<<AW)-1];

  logic          real_trig;
  logic          force_trig;
  logic          take_trig;
  logic          wr_en;
  logic [AW-1:0] wr_idx;

  assign state = st;

  // Trigger qualification. A real trigger needs a previous sample to
  // compare against, so the first sample after arming can never fire it.
  always_comb begin
    real_trig  = have_prev && (prev < trig_level) && (adc_data >= trig_level);
    force_trig = !real_trig && auto_mode && (tcnt == TW'(TIMEOUT - 1));
    take_trig  = (st == WAIT_TRIG) && adc_valid && (real_trig || force_trig);
    // Gated by rst: after a reset bank 0 is displayed, and the aborted
    // record must not land in it.
    wr_en      = !rst && (take_trig || ((st == CAPTURE) && adc_valid));
    // The trigger sample always starts the record at address 0.
    wr_idx     = (st == CAPTURE) ? wr_addr : '0;
  end

  // Capture always targets the bank that is not on screen.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{~disp_bank, wr_idx}] <= adc_data;
    end
  end

  // Display read port. Columns past the record width render as 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_data <= '0;
    end else if (value_x < 11'(DEPTH)) begin
      vga_data <= mem[{disp_bank, value_x[AW-1:0]}];
    end else begin
      vga_data <= '0;
    end
  end

  // Acquisition sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      disp_bank <= 1'b0;
      swapped   <= 1'b0;
      auto_trig <= 1'b0;
      wr_addr   <= '0;
      tcnt      <= '0;
      have_prev <= 1'b0;
      prev      <= '0;
      pend_auto <= 1'b0;
    end else begin
      swapped <= 1'b0;
      case (st)
        IDLE: begin
          wr_addr   <= '0;
          tcnt      <= '0;
          have_prev <= 1'b0;
          if (run || single) begin
            st <= WAIT_TRIG;
          end
        end

        WAIT_TRIG: begin
          if (adc_valid) begin
            prev      <= adc_data;
            have_prev <= 1'b1;
            // Saturate. With auto_mode set, the terminal count triggers
            // instead, so the counter never needs to wrap.
            if (tcnt != TW'(TIMEOUT - 1)) begin
              tcnt <= tcnt + TW'(1);
            end
            if (real_trig || force_trig) begin
              wr_addr   <= AW'(1);
              pend_auto <= force_trig;
              st        <= CAPTURE;
            end
          end
        end

        CAPTURE: begin
          // run is not consulted here. A started record always completes.
          if (adc_valid) begin
            if (wr_addr == AW'(DEPTH - 1)) begin
              st <= DONE;
            end else begin
              wr_addr <= wr_addr + AW'(1);
            end
          end
        end

        DONE: begin
          // Only a frame_sync seen while already in DONE swaps. A
          // frame_sync that coincides with the final write waits for the
          // next frame.
          if (frame_sync) begin
            disp_bank <= ~disp_bank;
            swapped   <= 1'b1;
            auto_trig <= pend_auto;
            tcnt      <= '0;
            have_prev <= 1'b0;
            wr_addr   <= '0;
            st        <= run ? WAIT_TRIG : IDLE;
          end
        end

        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_capture_ctrl.sv
module tb_wave_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  adc_data;
  logic        adc_valid;
  logic [7:0]  trig_level;
  logic        auto_mode;
  logic        run;
  logic        single;
  logic        frame_sync;
  logic [10:0] value_x;
  logic [7:0]  vga_data;
  logic [1:0]  state;
  logic        swapped;
  logic        auto_trig;

  always #5 clk = ~clk;

  wave_capture_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .trig_level (trig_level),
    .auto_mode  (auto_mode),
    .run        (run),
    .single     (single),
    .frame_sync (frame_sync),
    .value_x    (value_x),
    .vga_data   (vga_data),
    .state      (state),
    .swapped    (swapped),
    .auto_trig  (auto_trig)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total = total + 1;
    if (act == exp) passed = passed + 1;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // The model tracks the displayed record as an array and the record being
  // built as a queue. Banks are not modelled. After a reset the displayed
  // contents are unknown, so in-range reads are not checked until the next
  // swap.
  int  m_st, m_swp, m_at, m_pend, m_vga, m_tcnt, m_prev;
  bit  m_hp, m_vk, m_dk, m_ready = 1'b0;
  int  disp [200];
  int  rec [$];

  always @(posedge clk) begin : mdl
    int  vx, d;
    bit  trig, frc;
    vx = int'(value_x);
    d  = int'(adc_data);
    if (rst) begin
      m_st = 0; m_swp = 0; m_at = 0; m_pend = 0; m_vga = 0; m_vk = 1'b1;
      m_dk = 1'b0; m_tcnt = 0; m_hp = 1'b0; m_prev = 0; rec.delete();
      m_ready = 1'b1;
    end else if (m_ready) begin
      if (vx >= 200) begin
        m_vga = 0; m_vk = 1'b1;
      end else begin
        m_vga = disp[vx]; m_vk = m_dk;
      end
      m_swp = 0;
      case (m_st)
        0: begin
          m_tcnt = 0; m_hp = 1'b0; rec.delete();
          if (run || single) m_st = 1;
        end
        1: if (adc_valid) begin
          trig = m_hp && (m_prev < int'(trig_level)) && (d >= int'(trig_level));
          frc  = !trig && auto_mode && (m_tcnt == 4095);
          if (trig || frc) begin
            rec.delete(); rec.push_back(d); m_pend = frc ? 1 : 0; m_st = 2;
          end
          m_prev = d; m_hp = 1'b1;
          if (m_tcnt < 4095) m_tcnt = m_tcnt + 1;
        end
        2: if (adc_valid) begin
          rec.push_back(d);
          if (rec.size() == 200) m_st = 3;
        end
        default: if (frame_sync) begin
          for (int i = 0; i < 200; i++) disp[i] = rec[i];
          m_dk = 1'b1; m_swp = 1; m_at = m_pend;
          m_st = run ? 1 : 0; m_tcnt = 0; m_hp = 1'b0;
        end
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ready) begin
      chk("state", int'(state), m_st);
      chk("swapped", int'(swapped), m_swp);
      chk("auto_trig", int'(auto_trig), m_at);
      if (m_vk) chk("vga_data", int'(vga_data), m_vga);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int v);
    adc_valid = 1'b1;
    adc_data  = 8'(v);
    step();
    adc_valid = 1'b0;
  endtask

  task automatic rd(input int x, output int v);
    value_x = 11'(x);
    step();
    v = int'(vga_data);
  endtask

  task automatic fsync();
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
  endtask

  initial begin
    int v;
    rst = 1'b1; adc_data = '0; adc_valid = 1'b0; trig_level = 8'd128;
    auto_mode = 1'b0; run = 1'b0; single = 1'b0; frame_sync = 1'b0;
    value_x = 11'd250;
    step(); step();
    rst = 1'b0;
    chk("reset_state", int'(state), 0);
    chk("reset_vga", int'(vga_data), 0);
    chk("reset_swapped", int'(swapped), 0);
    chk("reset_auto_trig", int'(auto_trig), 0);

    // 1: ramp with level 128 fires on sample 128
    run = 1'b1; step();
    chk("t1_armed", int'(state), 1);
    for (int i = 0; i < 128; i++) put(i);
    chk("t1_no_early_trig", int'(state), 1);
    put(128);
    chk("t1_trig", int'(state), 2);
    for (int i = 129; i < 328; i++) put(i % 256);
    chk("t1_done", int'(state), 3);
    run = 1'b0;
    fsync();
    chk("t1_swapped", int'(swapped), 1);
    chk("t1_idle", int'(state), 0);
    rd(0, v);   chk("t1_x0", v, 128);
    chk("t1_swap_one_cycle", int'(swapped), 0);
    rd(100, v); chk("t1_x100", v, 228);
    rd(199, v); chk("t1_x199", v, 71);
    rd(200, v); chk("t1_x200", v, 0);
    for (int x = 0; x < 200; x++) rd(x, v);

    // 2: level crossing needs prev < level
    run = 1'b1; step();
    put(200); put(200);
    chk("t2_flat_high", int'(state), 1);
    put(50);
    chk("t2_falling", int'(state), 1);
    put(130);
    chk("t2_trig", int'(state), 2);
    for (int i = 0; i < 199; i++) put(7);
    run = 1'b0;
    fsync();
    chk("t2_swapped", int'(swapped), 1);
    rd(0, v); chk("t2_x0", v, 130);
    rd(1, v); chk("t2_x1", v, 7);

    // 3: forced trigger on the 4096th valid sample
    auto_mode = 1'b1; run = 1'b1; step();
    for (int i = 0; i < 4095; i++) put(10);
    chk("t3_before_force", int'(state), 1);
    put(10);
    chk("t3_forced", int'(state), 2);
    for (int i = 0; i < 199; i++) put(10);
    chk("t3_done", int'(state), 3);
    run = 1'b0;
    fsync();
    chk("t3_auto_trig", int'(auto_trig), 1);
    auto_mode = 1'b0;
    rd(0, v);   chk("t3_x0", v, 10);
    rd(199, v); chk("t3_x199", v, 10);
    for (int x = 0; x < 200; x++) rd(x, v);

    // 4: single shot, a second single during capture is ignored
    single = 1'b1; step(); single = 1'b0;
    chk("t4_armed", int'(state), 1);
    put(5); put(200);
    chk("t4_trig", int'(state), 2);
    single = 1'b1; put(9); single = 1'b0;
    chk("t4_single_ignored", int'(state), 2);
    for (int i = 0; i < 198; i++) put(9);
    chk("t4_done", int'(state), 3);
    fsync();
    chk("t4_swapped", int'(swapped), 1);
    chk("t4_idle", int'(state), 0);
    chk("t4_auto_clear", int'(auto_trig), 0);
    rd(0, v); chk("t4_x0", v, 200);

    // 5: frame_sync coinciding with the last write does not swap
    single = 1'b1; step(); single = 1'b0;
    put(0); put(150);
    chk("t5_trig", int'(state), 2);
    for (int i = 0; i < 198; i++) put(33);
    adc_valid = 1'b1; adc_data = 8'd33; frame_sync = 1'b1;
    step();
    adc_valid = 1'b0; frame_sync = 1'b0;
    chk("t5_done", int'(state), 3);
    chk("t5_no_swap", int'(swapped), 0);
    rd(0, v); chk("t5_old_x0", v, 200);
    chk("t5_still_done", int'(state), 3);
    fsync();
    chk("t5_swapped", int'(swapped), 1);
    rd(0, v); chk("t5_new_x0", v, 150);
    rd(1, v); chk("t5_new_x1", v, 33);

    // 6: reset during capture
    run = 1'b1; step();
    put(0); put(200); put(1); put(2);
    chk("t6_capture", int'(state), 2);
    value_x = 11'd3;
    rst = 1'b1; step(); run = 1'b0; rst = 1'b0;
    chk("t6_state", int'(state), 0);
    chk("t6_vga", int'(vga_data), 0);
    chk("t6_swapped", int'(swapped), 0);
    chk("t6_auto_trig", int'(auto_trig), 0);
    rd(250, v); chk("t6_x250", v, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 20000; c++) begin
      rst        = ($urandom_range(0, 1999) == 0);
      adc_valid  = ($urandom_range(0, 3) != 0);
      adc_data   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 499) == 0) trig_level = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 999) == 0) auto_mode = ~auto_mode;
      if ($urandom_range(0, 299) == 0) run = ~run;
      single     = ($urandom_range(0, 49) == 0);
      frame_sync = ($urandom_range(0, 149) == 0);
      value_x    = 11'($urandom_range(0, 260));
      step();
    end
    rst = 1'b0; adc_valid = 1'b0; single = 1'b0; frame_sync = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
